// File: rtl/sync_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package  : sync_pkg                                                   |
// | Purpose  : Parameter limits and counter sizing for sync_debounce_bank |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
package sync_pkg;

   localparam int C_CHANNELS_MIN = 1;
   localparam int C_CHANNELS_MAX = 32;
   localparam int C_STAGES_MIN   = 2;
   localparam int C_STAGES_MAX   = 4;

   // Counter must hold 0..cycles-1 and never collapse to zero width.
   function automatic int cnt_width(input int cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_debounce_chan.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : sync_debounce_chan                                         |
// | Purpose  : One channel: synchronizer chain, debounce, edge pulses.    |
// |            Debounce counter present only with SYNC_DEBOUNCE_EN.       |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module sync_debounce_chan
   import sync_pkg::*;
#(
   parameter int   STAGES          = 2,
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   if (STAGES < C_STAGES_MIN || STAGES > C_STAGES_MAX) begin : g_bad_stages
      $error("sync_debounce_chan: STAGES out of range");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("sync_debounce_chan: DEBOUNCE_CYCLES must be >= 1");
   end

   logic [STAGES-1:0] r_chain;
   logic              r_level;
   logic              r_rise;
   logic              r_fall;
   logic              w_sync;
   logic              w_update;

   assign w_sync = r_chain[STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_chain <= {STAGES{RESET_VAL}};
      end else begin
         r_chain <= {r_chain[STAGES-2:0], async_i};
      end
   end

`ifdef SYNC_DEBOUNCE_EN
   localparam int              C_CW   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [C_CW-1:0] C_LAST = C_CW'(DEBOUNCE_CYCLES - 1);

   logic [C_CW-1:0] r_cnt;

   assign w_update = (w_sync != r_level) && (r_cnt == C_LAST);

   // Any return to the current level restarts the stability window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_sync == r_level || r_cnt == C_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + C_CW'(1);
      end
   end
`else
   assign w_update = (w_sync != r_level);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_level <= RESET_VAL;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         if (w_update) begin
            r_level <= w_sync;
         end
         r_rise <= w_update &  w_sync;
         r_fall <= w_update & ~w_sync;
      end
   end

   assign level_o = r_level;
   assign rise_o  = r_rise;
   assign fall_o  = r_fall;

endmodule
`default_nettype wire

// File: rtl/sync_debounce_bank.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : sync_debounce_bank                                         |
// | Purpose  : Bank of independent synchronize/debounce channels.         |
// |            Define SYNC_DEBOUNCE_EN to enable the debounce counters.   |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module sync_debounce_bank
   import sync_pkg::*;
#(
   parameter int                  CHANNELS        = 4,
   parameter int                  STAGES          = 2,
   parameter int                  DEBOUNCE_CYCLES = 4,
   parameter logic [CHANNELS-1:0] RESET_VAL       = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] async_i,
   output logic [CHANNELS-1:0] level_o,
   output logic [CHANNELS-1:0] rise_o,
   output logic [CHANNELS-1:0] fall_o
);

   if (CHANNELS < C_CHANNELS_MIN || CHANNELS > C_CHANNELS_MAX) begin : g_bad_channels
      $error("sync_debounce_bank: CHANNELS out of range");
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      sync_debounce_chan #(
         .STAGES          (STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (RESET_VAL[i])
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .async_i (async_i[i]),
         .level_o (level_o[i]),
         .rise_o  (rise_o[i]),
         .fall_o  (fall_o[i])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_sync_debounce_bank.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_sync_debounce_bank                                      |
// | Purpose  : Directed self-checking bench; expectations follow          |
// |            SYNC_DEBOUNCE_EN (latency 6 with counters, 3 without).     |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module tb_sync_debounce_bank;

`ifdef SYNC_DEBOUNCE_EN
   localparam int C_LAT = 6;
   localparam int C_DEB = 1;
`else
   localparam int C_LAT = 3;
   localparam int C_DEB = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] r_async    = 4'b0000;
   logic [3:0] r_async_rv = 4'b1010;
   logic [3:0] w_level, w_rise, w_fall;
   logic [3:0] w_level_rv, w_rise_rv, w_fall_rv;

   int n_checks = 0;
   int n_pass   = 0;

   int         lvl_edge, rise_edge, fall_edge, rise_cnt, fall_cnt;
   logic [3:0] rise_val, fall_val;
   logic [3:0] rv_seen = 4'b0000;

   always #5 clk = ~clk;

   sync_debounce_bank #(
      .CHANNELS(4), .STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VAL(4'b0000)
   ) dut (
      .clk(clk), .rst(rst), .async_i(r_async),
      .level_o(w_level), .rise_o(w_rise), .fall_o(w_fall)
   );

   sync_debounce_bank #(
      .CHANNELS(4), .STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VAL(4'b1010)
   ) dut_rv (
      .clk(clk), .rst(rst), .async_i(r_async_rv),
      .level_o(w_level_rv), .rise_o(w_rise_rv), .fall_o(w_fall_rv)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Observe n edges; after edge 'hold' drive r_async to 'after'.
   task automatic watch(input int n, input int hold, input logic [3:0] after);
      logic [3:0] start_lvl;
      start_lvl = w_level;
      lvl_edge = -1; rise_edge = -1; fall_edge = -1;
      rise_cnt = 0;  fall_cnt = 0;
      rise_val = 4'b0000; fall_val = 4'b0000;
      for (int e = 1; e <= n; e++) begin
         @(posedge clk);
         #1;
         if (lvl_edge < 0 && w_level != start_lvl) lvl_edge = e;
         if (w_rise != 4'b0000) begin
            rise_cnt++;
            if (rise_edge < 0) begin rise_edge = e; rise_val = w_rise; end
         end
         if (w_fall != 4'b0000) begin
            fall_cnt++;
            if (fall_edge < 0) begin fall_edge = e; fall_val = w_fall; end
         end
         rv_seen = rv_seen | w_rise_rv | w_fall_rv;
         if (e == hold) r_async = after;
      end
   endtask

   initial begin
      // Reset state
      tick(3);
      chk("rst_level",    int'(w_level),    0);
      chk("rst_pulses",   int'(w_rise | w_fall), 0);
      chk("rst_level_rv", int'(w_level_rv), 'b1010);
      chk("rst_pulse_rv", int'(w_rise_rv | w_fall_rv), 0);
      rst = 1'b0;

      // Clean release: no pulses from reset alone
      watch(8, 100, 4'b0000);
      chk("release_rise", rise_cnt, 0);
      chk("release_fall", fall_cnt, 0);

      // Step ch0 and hold
      r_async = 4'b0001;
      watch(C_LAT + 4, 100, 4'b0000);
      chk("step_lvl_edge",  lvl_edge,  C_LAT);
      chk("step_level",     int'(w_level), 'b0001);
      chk("step_rise_edge", rise_edge, C_LAT);
      chk("step_rise_val",  int'(rise_val), 'b0001);
      chk("step_rise_cnt",  rise_cnt,  1);
      chk("step_fall_cnt",  fall_cnt,  0);
      r_async = 4'b0000;
      watch(C_LAT + 4, 100, 4'b0000);
      chk("stepdn_fall_edge", fall_edge, C_LAT);
      chk("stepdn_fall_val",  int'(fall_val), 'b0001);
      chk("stepdn_level",     int'(w_level), 0);

      // Two-cycle glitch on ch1
      r_async = 4'b0010;
      watch(14, 2, 4'b0000);
      chk("glitch_rise_cnt", rise_cnt, C_DEB ? 0 : 1);
      chk("glitch_fall_cnt", fall_cnt, C_DEB ? 0 : 1);
      chk("glitch_lvl_edge", lvl_edge, C_DEB ? -1 : 3);
      chk("glitch_level",    int'(w_level), 0);

      // All channels together, held 10 cycles
      r_async = 4'b1111;
      watch(24, 10, 4'b0000);
      chk("all_rise_edge", rise_edge, C_LAT);
      chk("all_rise_val",  int'(rise_val), 'b1111);
      chk("all_rise_cnt",  rise_cnt, 1);
      chk("all_fall_edge", fall_edge, 10 + C_LAT);
      chk("all_fall_val",  int'(fall_val), 'b1111);
      chk("all_fall_cnt",  fall_cnt, 1);

      // Reset mid-debounce on ch2
      r_async = 4'b0100;
      tick(3);
      rst = 1'b1;
      #1;
      chk("midrst_level",  int'(w_level), 0);
      chk("midrst_pulses", int'(w_rise | w_fall), 0);
      chk("midrst_lvl_rv", int'(w_level_rv), 'b1010);
      tick(2);
      r_async = 4'b0000;
      rst = 1'b0;
      watch(12, 100, 4'b0000);
      chk("midrst_rise_cnt", rise_cnt, 0);
      chk("midrst_fall_cnt", fall_cnt, 0);
      chk("midrst_level2",   int'(w_level), 0);

      // One-cycle synchronized pulse on ch3
      r_async = 4'b1000;
      watch(12, 1, 4'b0000);
      chk("pulse3_rise_edge", rise_edge, C_DEB ? -1 : 3);
      chk("pulse3_fall_edge", fall_edge, C_DEB ? -1 : 4);
      chk("pulse3_rise_val",  int'(rise_val), C_DEB ? 0 : 'b1000);
      chk("pulse3_level",     int'(w_level), 0);

      // RESET_VAL instance never pulsed with matching input
      chk("rv_no_pulse", int'(rv_seen), 0);
      chk("rv_level",    int'(w_level_rv), 'b1010);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sync_debounce_bank.md
SYNC_DEBOUNCE_BANK -- requirements
Module: sync_debounce_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent asynchronous input channels (legal range 1..32).
REQ-002 SHALL have parameter STAGES, default 2: synchronizer flop depth per channel (legal range 2..4).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized cycles required before the output level changes (legal range >= 1).
REQ-004 SHALL have parameter RESET_VAL, default all-zero, width CHANNELS: per-channel reset level.
REQ-005 SHALL have port clk, input, 1: clock.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port async_i, input, CHANNELS: asynchronous raw inputs.
REQ-008 SHALL have port level_o, output, CHANNELS: synchronized, debounced level.
REQ-009 SHALL have port rise_o, output, CHANNELS: one-cycle pulse when level_o goes 0->1.
REQ-010 SHALL have port fall_o, output, CHANNELS: one-cycle pulse when level_o goes 1->0.

Function
REQ-011 SHALL pass each channel through a STAGES-deep flop chain; the last stage is the synchronized value `sync`.
REQ-012 SHALL keep a per-channel counter of width max(1, clog2(DEBOUNCE_CYCLES)).
REQ-013 When sync equals level_o, the counter SHALL clear to 0 on the next edge.
REQ-014 When sync differs from level_o and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-015 When sync differs from level_o and the counter equals DEBOUNCE_CYCLES-1, on that edge level_o SHALL take sync and the counter SHALL clear.
REQ-016 Latency: an input change held stable SHALL appear on level_o after exactly STAGES+DEBOUNCE_CYCLES rising edges.
REQ-017 A synchronized glitch lasting fewer than DEBOUNCE_CYCLES cycles SHALL leave level_o unchanged and produce no pulse.
REQ-018 rise_o and fall_o SHALL be registered and asserted in the same cycle that level_o first shows the new value, for exactly one cycle.
REQ-019 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each produce their own pulses in the same cycle.
REQ-020 Out-of-range parameters SHALL cause an elaboration-time error.

Reset
REQ-021 While rst is high, all synchronizer stages and level_o SHALL equal RESET_VAL, and counters, rise_o and fall_o SHALL be 0.
REQ-022 Reset asserted mid-debounce SHALL discard the pending change; after release no pulse SHALL fire for the transition back to RESET_VAL.
REQ-023 The first edge after rst deasserts SHALL begin normal sampling, and SHALL NOT generate pulses from reset alone.

Configuration
REQ-024 Macro SYNC_DEBOUNCE_EN defined: counters present; behaviour per REQ-012..REQ-017.
REQ-025 Macro SYNC_DEBOUNCE_EN undefined: no counters; level_o SHALL register sync every cycle (identical to DEBOUNCE_CYCLES=1), with latency STAGES+1; the DEBOUNCE_CYCLES parameter SHALL be ignored.

Structure
REQ-026 Package sync_pkg SHALL hold the STAGES/CHANNELS limits and the counter-width function.
REQ-027 Sub-module sync_debounce_chan SHALL implement one channel (chain, counter, level, pulses); the top SHALL generate CHANNELS instances.

Verification (CHANNELS=4, STAGES=2, DEBOUNCE_CYCLES=4, RESET_VAL=4'b0000 unless noted)
REQ-028 Step ch0 0->1 and hold -> level_o[0]=1 after edge 6, rise_o[0]=1 for that single cycle, other bits quiet.
REQ-029 Pulse ch1 high for 2 cycles -> level_o[1] stays 0, rise_o and fall_o stay 0.
REQ-030 Drive async_i 4'b0000->4'b1111 together, hold 10 cycles, return to 0 -> all rise_o bits assert in the same cycle, then all fall_o bits assert in the same cycle 6 edges after the return.
REQ-031 Assert rst 3 cycles after ch2 rises -> level_o=0, no pulses; after release with async_i=0 no pulses occur.
REQ-032 RESET_VAL=4'b1010 -> level_o=4'b1010 in reset; release with async_i=4'b1010 produces no pulses.
REQ-033 SYNC_DEBOUNCE_EN undefined: ch3 1-cycle synchronized pulse -> level_o[3] follows at edge 3, rise_o[3] then fall_o[3] in consecutive cycles.
